// File: rtl/id_scoreboard_pkg.sv
// Shared widths and types for the ID-stage register scoreboard.
// Optional WB bypass is enabled by defining SB_WB_BYPASS_EN.
package id_scoreboard_pkg;

    localparam int unsigned REG_NUM = 32;
    localparam int unsigned CNT_WD  = 2;
    localparam int unsigned AW      = $clog2(REG_NUM);

    typedef logic [AW-1:0]     reg_addr_t;
    typedef logic [CNT_WD-1:0] cnt_t;

    localparam cnt_t CNT_MAX = {CNT_WD{1'b1}};

endpackage

// File: rtl/id_scoreboard_if.sv
// ID decode / WB writeback / interlock bundle between ID_stage and the scoreboard.
interface id_scoreboard_if;
    import id_scoreboard_pkg::*;

    logic                id_valid;
    logic                id_rs1_en;
    reg_addr_t           id_rs1;
    logic                id_rs2_en;
    reg_addr_t           id_rs2;
    logic                id_rd_en;
    reg_addr_t           id_rd;
    logic                exe_allow_in;
    logic                wb_w_en;
    reg_addr_t           wb_w_addr;
    logic                pipe_flush;
    logic                id_ready_go;
    logic                id_issue;
    logic [REG_NUM-1:0]  busy_vec;
    logic                sb_err;
    logic                id_fwd1;
    logic                id_fwd2;

    modport master (
        output id_valid, id_rs1_en, id_rs1, id_rs2_en, id_rs2, id_rd_en, id_rd,
               exe_allow_in, wb_w_en, wb_w_addr, pipe_flush,
        input  id_ready_go, id_issue, busy_vec, sb_err, id_fwd1, id_fwd2
    );

    modport slave (
        input  id_valid, id_rs1_en, id_rs1, id_rs2_en, id_rs2, id_rd_en, id_rd,
               exe_allow_in, wb_w_en, wb_w_addr, pipe_flush,
        output id_ready_go, id_issue, busy_vec, sb_err, id_fwd1, id_fwd2
    );

endinterface

// File: rtl/id_scoreboard_sb_reg_cnt.sv
// One pending-writer counter: up on issue, down on retire, cleared by flush.
module id_scoreboard_sb_reg_cnt
    import id_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output cnt_t cnt,
    output logic underflow
);

    cnt_t cnt_q, cnt_d;

    // Flush wins; simultaneous inc/dec cancel; retire on empty flags underflow.
    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_WD'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) underflow = 1'b1;
            else             cnt_d     = cnt_q - CNT_WD'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_scoreboard.sv
// ID-stage RAW/WAW interlock: per-GPR pending-writer counters gate id_ready_go.
// Define SB_WB_BYPASS_EN to let a source retiring this cycle bypass from WB.
module id_scoreboard
    import id_scoreboard_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    id_scoreboard_if.slave sb
);

    cnt_t               cnt [REG_NUM];
    logic [REG_NUM-1:0] uflow;
    logic [REG_NUM-1:0] busy;
    logic               sb_err_q, sb_err_d;
    logic               ready_go, issue;
    logic               byp1, byp2, haz1, haz2, waw_full;
    cnt_t               c1, c2, cd;

    assign cnt[0]   = '0;
    assign uflow[0] = 1'b0;
    assign busy[0]  = 1'b0;

    for (genvar i = 1; i < REG_NUM; i++) begin : g_cnt
        logic inc_i, dec_i;
        assign inc_i = issue && sb.id_rd_en && (sb.id_rd == AW'(i));
        assign dec_i = sb.wb_w_en && (sb.wb_w_addr == AW'(i));

        id_scoreboard_sb_reg_cnt u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_i),
            .dec       (dec_i),
            .clr       (sb.pipe_flush),
            .cnt       (cnt[i]),
            .underflow (uflow[i])
        );

        assign busy[i] = (cnt[i] != '0);
    end

    // Hazard compare against registered counters; zero-cycle path to ready_go.
    always_comb begin
        c1 = cnt[sb.id_rs1];
        c2 = cnt[sb.id_rs2];
        cd = cnt[sb.id_rd];
`ifdef SB_WB_BYPASS_EN
        byp1 = sb.wb_w_en && (sb.wb_w_addr == sb.id_rs1) && (c1 == CNT_WD'(1));
        byp2 = sb.wb_w_en && (sb.wb_w_addr == sb.id_rs2) && (c2 == CNT_WD'(1));
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        haz1     = sb.id_rs1_en && (sb.id_rs1 != '0) && (c1 != '0) && !byp1;
        haz2     = sb.id_rs2_en && (sb.id_rs2 != '0) && (c2 != '0) && !byp2;
        waw_full = sb.id_rd_en  && (sb.id_rd  != '0) && (cd == CNT_MAX);
        ready_go = !(haz1 || haz2 || waw_full);
        issue    = sb.id_valid && ready_go && sb.exe_allow_in;
        sb_err_d = sb_err_q || (|uflow);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sb_err_q <= 1'b0;
        else        sb_err_q <= sb_err_d;
    end

    assign sb.id_ready_go = ready_go;
    assign sb.id_issue    = issue;
    assign sb.busy_vec    = busy;
    assign sb.sb_err      = sb_err_q;
    assign sb.id_fwd1     = sb.id_rs1_en && (sb.id_rs1 != '0) && byp1;
    assign sb.id_fwd2     = sb.id_rs2_en && (sb.id_rs2 != '0) && byp2;

endmodule
